// File: rtl/cluster_pkg.sv
// Shared types for the processor-cluster dispatch path: address type and the
// state encodings used by each per-processor dispatch port.
package cluster_pkg;

  localparam int ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } core_state_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } snd_state_t;

endpackage

// File: rtl/spawn_fifo.sv
// Register FIFO holding spawn addresses; the head stays put until popped so the
// sender can re-read it while a request is in flight.
module spawn_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/proc_dispatch_port.sv
// Per-processor endpoint to the Dispatcher: forwards queued spawns over a toggle
// handshake and turns the Dispatcher's start level into a one-cycle core start.
//
// core state | meaning
// IDLE       | slot free, waiting for a proc_start rising edge
// RUN        | core executing, spawns accepted
// DRAIN      | core finished, undelivered spawns still being sent
// sender     | meaning
// S_IDLE     | no request in flight
// S_WAIT     | request toggled out, waiting for matching proc_ack
module proc_dispatch_port #(
  parameter int ADDR_W      = 8,
  parameter int SPAWN_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spawn_valid,
  input  logic [ADDR_W-1:0] spawn_addr,
  output logic              spawn_ready,
  input  logic              core_done,
  output logic              core_start,
  output logic [ADDR_W-1:0] core_start_addr,
  output logic              proc_running,
  output logic [ADDR_W-1:0] proc_spawn_addr,
  output logic              proc_onspawn,
  input  logic              proc_ack,
  input  logic              proc_start,
  input  logic [ADDR_W-1:0] proc_start_addr,
  output logic              err_start
);
  import cluster_pkg::*;

  localparam int CW = $clog2(SPAWN_DEPTH) + 1;

  core_state_t       state, state_nxt;
  snd_state_t        snd, snd_nxt;
  logic              last_start;
  logic              start_edge;
  logic              start_pulse;
  logic              toggle;
  logic              push, pop, full, empty;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] head;

  assign start_edge   = proc_start & ~last_start;
  assign spawn_ready  = (state == RUN) & ~full;
  assign push         = spawn_valid & spawn_ready;
  assign pop          = (snd == S_WAIT) & (proc_ack == proc_onspawn);
  assign proc_running = (state != IDLE);

  spawn_fifo #(.W(ADDR_W), .DEPTH(SPAWN_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (spawn_addr),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_comb begin
    state_nxt   = state;
    start_pulse = 1'b0;
    case (state)
      IDLE: if (start_edge) begin
        state_nxt   = RUN;
        start_pulse = 1'b1;
      end
      RUN: if (core_done) begin
        // a push landing with core_done still has to be delivered
        state_nxt = (empty && snd == S_IDLE && !push) ? IDLE : DRAIN;
      end
      DRAIN: if ((pop && count == CW'(1)) || (empty && snd == S_IDLE)) begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snd_nxt = snd;
    toggle  = 1'b0;
    case (snd)
      S_IDLE: if (!empty) begin
        snd_nxt = S_WAIT;
        toggle  = 1'b1;
      end
      S_WAIT: if (pop) snd_nxt = S_IDLE;
      default: snd_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      snd             <= S_IDLE;
      last_start      <= 1'b0;
      core_start      <= 1'b0;
      core_start_addr <= '0;
      proc_onspawn    <= 1'b0;
      proc_spawn_addr <= '0;
      err_start       <= 1'b0;
    end else begin
      state      <= state_nxt;
      snd        <= snd_nxt;
      last_start <= proc_start;
      core_start <= start_pulse;
      if (start_pulse) core_start_addr <= proc_start_addr;
      if (toggle) begin
        proc_onspawn    <= ~proc_onspawn;
        proc_spawn_addr <= head;
      end
      if (start_edge && state != IDLE) err_start <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_dispatch_port.sv
// Directed + randomized bench for proc_dispatch_port; a queue of unacknowledged
// spawn addresses serves as the reference for ready, addresses and handshake.
module tb_proc_dispatch_port;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          spawn_valid = 1'b0;
  logic [AW-1:0] spawn_addr = '0;
  logic          core_done = 1'b0;
  logic          proc_ack = 1'b0;
  logic          proc_start = 1'b0;
  logic [AW-1:0] proc_start_addr = '0;
  logic          spawn_ready, core_start, proc_running, proc_onspawn, err_start;
  logic [AW-1:0] core_start_addr, proc_spawn_addr;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] q[$];
  logic [AW-1:0] a0, a1, r2;
  bit            exp_ready, do_ack;

  proc_dispatch_port #(.ADDR_W(AW), .SPAWN_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .spawn_valid     (spawn_valid),
    .spawn_addr      (spawn_addr),
    .spawn_ready     (spawn_ready),
    .core_done       (core_done),
    .core_start      (core_start),
    .core_start_addr (core_start_addr),
    .proc_running    (proc_running),
    .proc_spawn_addr (proc_spawn_addr),
    .proc_onspawn    (proc_onspawn),
    .proc_ack        (proc_ack),
    .proc_start      (proc_start),
    .proc_start_addr (proc_start_addr),
    .err_start       (err_start)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_ready"},   32'(spawn_ready), 32'd0);
    chk({tag, "_cstart"},  32'(core_start), 32'd0);
    chk({tag, "_caddr"},   32'(core_start_addr), 32'd0);
    chk({tag, "_running"}, 32'(proc_running), 32'd0);
    chk({tag, "_saddr"},   32'(proc_spawn_addr), 32'd0);
    chk({tag, "_onspawn"}, 32'(proc_onspawn), 32'd0);
    chk({tag, "_err"},     32'(err_start), 32'd0);
  endtask

  task automatic push_one(input logic [AW-1:0] a);
    chk("push_ready", 32'(spawn_ready), 32'd1);
    spawn_valid = 1'b1;
    spawn_addr  = a;
    step();
    spawn_valid = 1'b0;
    q.push_back(a);
  endtask

  // Wait (bounded) for an outstanding request, check its address, ack it.
  task automatic ack_one();
    int n = 0;
    while (proc_onspawn === proc_ack && n < 10) begin
      step();
      n++;
    end
    chk("ack_wait_toggle", 32'(proc_onspawn !== proc_ack), 32'd1);
    chk("ack_addr", 32'(proc_spawn_addr), (q.size() > 0) ? 32'(q[0]) : 32'hDEAD);
    proc_ack = proc_onspawn;
    step();
    if (q.size() > 0) void'(q.pop_front());
  endtask

  initial begin
    // reset held two cycles
    step();
    step();
    outputs_zero("reset");
    reset = 1'b0;
    step();

    // start held 5 cycles: single pulse, address captured on the edge only
    proc_start_addr = 8'h10;
    proc_start      = 1'b1;
    step();
    chk("start_pulse", 32'(core_start), 32'd1);
    chk("start_addr", 32'(core_start_addr), 32'h10);
    chk("start_running", 32'(proc_running), 32'd1);
    chk("start_err", 32'(err_start), 32'd0);
    proc_start_addr = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("start_single", 32'(core_start), 32'd0);
      chk("start_addr_hold", 32'(core_start_addr), 32'h10);
    end
    proc_start = 1'b0;
    step();

    // single spawn: toggle one cycle after acceptance, ack 3 cycles later
    a0 = 8'h2A;
    push_one(a0);
    chk("spawn_latency", 32'(proc_onspawn), 32'd0);
    step();
    chk("spawn_toggle", 32'(proc_onspawn), 32'd1);
    chk("spawn_addr", 32'(proc_spawn_addr), 32'h2A);
    repeat (3) step();
    proc_ack = 1'b1;
    step();
    void'(q.pop_front());
    chk("single_ready_after", 32'(spawn_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_extra_toggle", 32'(proc_onspawn), 32'd1);
    end

    // full: 4 pushes with ack withheld
    for (int i = 1; i <= DEPTH; i++) push_one(8'(i));
    chk("full_ready", 32'(spawn_ready), 32'd0);
    step();
    chk("full_ready_hold", 32'(spawn_ready), 32'd0);
    ack_one();
    chk("full_ready_after_ack", 32'(spawn_ready), 32'd1);
    step();
    chk("full_next_toggle", 32'(proc_onspawn !== proc_ack), 32'd1);
    chk("full_next_addr", 32'(proc_spawn_addr), 32'h02);
    for (int i = 0; i < 3; i++) ack_one();
    step();
    chk("full_drained", 32'(proc_onspawn), 32'(proc_ack));

    // randomized traffic against the queue model
    for (int c = 0; c < 80; c++) begin
      exp_ready = (q.size() < DEPTH);
      chk("rnd_ready", 32'(spawn_ready), 32'(exp_ready));
      if (proc_onspawn !== proc_ack)
        chk("rnd_addr", 32'(proc_spawn_addr), (q.size() > 0) ? 32'(q[0]) : 32'hDEAD);
      if (q.size() == 0)
        chk("rnd_idle_handshake", 32'(proc_onspawn), 32'(proc_ack));
      do_ack = (proc_onspawn !== proc_ack) && ($urandom_range(2) == 0);
      if (do_ack) proc_ack = proc_onspawn;
      spawn_valid = 1'($urandom_range(1));
      spawn_addr  = 8'($urandom);
      step();
      if (do_ack) void'(q.pop_front());
      if (spawn_valid && exp_ready) q.push_back(spawn_addr);
    end
    spawn_valid = 1'b0;
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) ack_one();
    chk("rnd_all_acked", 32'(q.size()), 32'd0);

    // drain: two pending then core_done
    a0 = 8'($urandom);
    a1 = 8'($urandom);
    push_one(a0);
    push_one(a1);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("drain_running", 32'(proc_running), 32'd1);
    chk("drain_ready", 32'(spawn_ready), 32'd0);
    ack_one();
    chk("drain_hold", 32'(proc_running), 32'd1);
    chk("drain_ready_hold", 32'(spawn_ready), 32'd0);
    ack_one();
    chk("drain_done", 32'(proc_running), 32'd0);

    // restart, then core_done with nothing pending
    a0 = 8'($urandom);
    proc_start_addr = a0;
    proc_start = 1'b1;
    step();
    chk("restart_pulse", 32'(core_start), 32'd1);
    chk("restart_addr", 32'(core_start_addr), 32'(a0));
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("done_idle", 32'(proc_running), 32'd0);
    chk("done_ready", 32'(spawn_ready), 32'd0);
    proc_start = 1'b0;
    step();
    r2 = 8'($urandom);
    proc_start_addr = r2;
    proc_start = 1'b1;
    step();
    chk("start3_pulse", 32'(core_start), 32'd1);
    chk("start3_addr", 32'(core_start_addr), 32'(r2));

    // start edge while running is an error and is ignored
    proc_start = 1'b0;
    step();
    proc_start_addr = ~r2;
    proc_start = 1'b1;
    step();
    chk("viol_no_pulse", 32'(core_start), 32'd0);
    chk("viol_err", 32'(err_start), 32'd1);
    chk("viol_addr_kept", 32'(core_start_addr), 32'(r2));
    chk("viol_running", 32'(proc_running), 32'd1);
    step();
    chk("viol_err_sticky", 32'(err_start), 32'd1);

    // reset while a request is in flight
    push_one(8'($urandom));
    step();
    chk("rst_inflight", 32'(proc_onspawn !== proc_ack), 32'd1);
    reset      = 1'b1;
    proc_ack   = 1'b0;
    proc_start = 1'b0;
    step();
    outputs_zero("rst_wait");
    reset = 1'b0;
    q.delete();
    step();
    step();
    outputs_zero("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
